// File: rtl/ctrl_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_reg_bank
// Purpose  : Host/FPGA command register bank on the bus clock.
//            - Address 0          : control word, RW, synchronised to ctrl_out
//            - Address 1          : write-one-to-pulse command strobes (reads 0)
//            - 2 .. DEPTH-N_STAT-1: general RW registers
//            - DEPTH-N_STAT+i     : saturating status counter i
//                                   (read = count, any write clears it)
// Ports    : clk, rst_n          clock / asynchronous active-low reset
//            din, we, re, addr   host register port
//            dout, dout_valid    registered read data, one cycle after re
//            ctrl_out            register 0 after SYNC_STAGES flops
//            cmd_pulse           one-cycle copy of din written to address 1
//            stat_inc, stat_ovf  counter increment requests / sticky overflow
// Options  : STAT_SNAPSHOT_EN    reading counter 0 snapshots all counters;
//                                reads of counters 1..N_STAT-1 return the
//                                snapshot so a multi-counter readout is atomic.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_reg_bank #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 5,
  parameter int N_STAT      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] cmd_pulse,
  input  logic [N_STAT-1:0] stat_inc,
  output logic [N_STAT-1:0] stat_ovf
);

  localparam int                DEPTH      = 2**ADDR_W;
  localparam int                STAT_BASE  = DEPTH - N_STAT;
  localparam logic [ADDR_W-1:0] PULSE_ADDR = ADDR_W'(1);

  // Storage for addresses 0 .. STAT_BASE-1. Entry 1 is the pulse address and
  // never holds state; it stays at its reset value and is optimised away.
  logic [DATA_W-1:0] regs_q [STAT_BASE];
  logic [DATA_W-1:0] regs_d [STAT_BASE];
  logic [DATA_W-1:0] sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] sync_d [SYNC_STAGES];
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0] pulse_q, pulse_d;
  logic [DATA_W-1:0] rdata;

  // Per-counter read values, flattened so each generate block drives its slice
  logic [N_STAT*DATA_W-1:0] stat_rd_flat;

  // --------------------------------------------------------------------------
  // Host writes, read mux, pulse and sync chain
  // --------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int r = 0; r < STAT_BASE; r++) begin
        if (r != 1 && addr == ADDR_W'(r)) regs_d[r] = din;
      end
    end
  end

  // Read mux uses current (pre-write, pre-clear) state
  always_comb begin
    rdata = '0;
    for (int r = 0; r < STAT_BASE; r++) begin
      if (r != 1 && addr == ADDR_W'(r)) rdata = regs_q[r];
    end
    for (int i = 0; i < N_STAT; i++) begin
      if (addr == ADDR_W'(STAT_BASE + i)) rdata = stat_rd_flat[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    dout_d       = re ? rdata : dout_q;
    dout_valid_d = re;
    pulse_d      = (we && addr == PULSE_ADDR) ? din : '0;
    sync_d[0]    = regs_q[0];
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < STAT_BASE; r++) regs_q[r] <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      pulse_q      <= '0;
    end else begin
      for (int r = 0; r < STAT_BASE; r++) regs_q[r] <= regs_d[r];
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      pulse_q      <= pulse_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign cmd_pulse  = pulse_q;
  assign ctrl_out   = sync_q[SYNC_STAGES-1];

`ifdef STAT_SNAPSHOT_EN
  logic snap;
  assign snap = re && (addr == ADDR_W'(STAT_BASE));
`endif

  // --------------------------------------------------------------------------
  // Status counters
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_STAT; i++) begin : g_stat
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              clr;

    assign clr = we && (addr == ADDR_W'(STAT_BASE + i));

    // A clear coinciding with an increment keeps the event: count restarts at 1
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
        cnt_d = stat_inc[i] ? DATA_W'(1) : '0;
        ovf_d = 1'b0;
      end else if (stat_inc[i]) begin
        if (&cnt_q) ovf_d = 1'b1;
        else        cnt_d = cnt_q + DATA_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign stat_ovf[i] = ovf_q;

`ifdef STAT_SNAPSHOT_EN
    if (i == 0) begin : g_live
      // Counter 0 read returns live value, identical to what is snapshotted
      assign stat_rd_flat[i*DATA_W +: DATA_W] = cnt_q;
    end else begin : g_shadow
      logic [DATA_W-1:0] shadow_q, shadow_d;
      assign shadow_d = snap ? cnt_q : shadow_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
      end
      assign stat_rd_flat[i*DATA_W +: DATA_W] = shadow_q;
    end
`else
    assign stat_rd_flat[i*DATA_W +: DATA_W] = cnt_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_reg_bank
// Purpose  : Self-checking bench for ctrl_reg_bank with a behavioural model
//            (address-indexed arrays, integer counters, a delay queue for the
//            synchroniser) compared against the DUT on every falling edge,
//            plus literal expectations for the directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_ctrl_reg_bank;

  localparam int DW   = 16;
  localparam int AW   = 5;
  localparam int NS   = 4;
  localparam int SS   = 2;
  localparam int BASE = (1 << AW) - NS;
  localparam int MAXC = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [DW-1:0] ctrl_out;
  logic [DW-1:0] cmd_pulse;
  logic [NS-1:0] stat_inc = '0;
  logic [NS-1:0] stat_ovf;

  int checks = 0;
  int fails  = 0;

  ctrl_reg_bank #(
    .DATA_W(DW), .ADDR_W(AW), .N_STAT(NS), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .we(we), .re(re), .addr(addr),
    .dout(dout), .dout_valid(dout_valid), .ctrl_out(ctrl_out),
    .cmd_pulse(cmd_pulse), .stat_inc(stat_inc), .stat_ovf(stat_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: what each output must be after every rising edge
  // --------------------------------------------------------------------------
  logic [DW-1:0] m_reg [1 << AW];
  int            m_cnt [NS];
  bit            m_ovf [NS];
  int            m_shadow [NS];
  logic [DW-1:0] ctrl_hist [$];
  logic [DW-1:0] exp_dout  = '0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_pulse = '0;
  logic [DW-1:0] exp_ctrl  = '0;

  function automatic logic [DW-1:0] model_read(input int a);
    if (a == 1) return '0;
    if (a < BASE) return m_reg[a];
`ifdef STAT_SNAPSHOT_EN
    if (a != BASE) return DW'(m_shadow[a - BASE]);
`endif
    return DW'(m_cnt[a - BASE]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < (1 << AW); a++) m_reg[a] = '0;
      for (int i = 0; i < NS; i++) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_shadow[i] = 0;
      end
      ctrl_hist.delete();
      for (int s = 0; s < SS; s++) ctrl_hist.push_back('0);
      exp_dout = '0; exp_valid = 0; exp_pulse = '0; exp_ctrl = '0;
    end else begin
      int a;
      a = int'(addr);
      exp_valid = re;
      if (re) exp_dout = model_read(a);
`ifdef STAT_SNAPSHOT_EN
      if (re && a == BASE) for (int i = 0; i < NS; i++) m_shadow[i] = m_cnt[i];
`endif
      exp_pulse = (we && a == 1) ? din : '0;
      for (int i = 0; i < NS; i++) begin
        if (we && a == BASE + i) begin
          m_cnt[i] = stat_inc[i] ? 1 : 0;
          m_ovf[i] = 0;
        end else if (stat_inc[i]) begin
          if (m_cnt[i] == MAXC) m_ovf[i] = 1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (we && a < BASE && a != 1) m_reg[a] = din;
      ctrl_hist.push_back(m_reg[0]);
      exp_ctrl = ctrl_hist.pop_front();
    end
  end

  // Compare process: every falling edge, all outputs against the model
  always @(negedge clk) begin
    logic [NS-1:0] eo;
    for (int i = 0; i < NS; i++) eo[i] = m_ovf[i];
    chk("dout",       32'(dout),       32'(exp_dout));
    chk("dout_valid", 32'(dout_valid), 32'(exp_valid));
    chk("ctrl_out",   32'(ctrl_out),   32'(exp_ctrl));
    chk("cmd_pulse",  32'(cmd_pulse),  32'(exp_pulse));
    chk("stat_ovf",   32'(stat_ovf),   32'(eo));
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; re = 0; stat_inc = '0;
  endtask

  task automatic read_lit(input int a, input logic [DW-1:0] exp, input string name);
    re = 1; we = 0; addr = AW'(a);
    tick();
    re = 0;
    chk(name, 32'(dout), 32'(exp));
    chk({name, "_valid"}, 32'(dout_valid), 32'd1);
  endtask

  task automatic write(input int a, input logic [DW-1:0] d);
    we = 1; addr = AW'(a); din = d;
    tick();
    we = 0;
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset state
    chk("rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("rst_ovf",  32'(stat_ovf), 32'd0);
    read_lit(0, 16'h0000, "rst_rd0");
    read_lit(5, 16'h0000, "rst_rd5");
    for (int a = BASE; a < BASE + NS; a++) read_lit(a, 16'h0000, "rst_rdstat");
    tick();
    chk("valid_idle", 32'(dout_valid), 32'd0);

    // Control word latency through the synchroniser
    write(0, 16'h0001);
    chk("ctrl_k0", 32'(ctrl_out), 32'd0);
    tick();
    chk("ctrl_k1", 32'(ctrl_out), 32'd0);
    tick();
    chk("ctrl_k2", 32'(ctrl_out), 32'd1);
    read_lit(0, 16'h0001, "rd0");

    // Back-to-back command pulses
    write(1, 16'h00A5);
    chk("pulse_a5", 32'(cmd_pulse), 32'h00A5);
    write(1, 16'h0100);
    chk("pulse_100", 32'(cmd_pulse), 32'h0100);
    tick();
    chk("pulse_end", 32'(cmd_pulse), 32'd0);
    read_lit(1, 16'h0000, "rd1");

    // Counter 0: ten increments, then clear coinciding with an increment
    stat_inc = 4'b0001;
    repeat (10) tick();
    stat_inc = '0;
    read_lit(BASE, 16'd10, "cnt0_10");
    stat_inc = 4'b0001;
    write(BASE, 16'hFFFF);
    stat_inc = '0;
    read_lit(BASE, 16'd1, "cnt0_clrinc");

    // Counter 1: saturation and sticky overflow, then write-clear
    stat_inc = 4'b0010;
    repeat (65540) tick();
    stat_inc = '0;
    chk("ovf1_set", 32'(stat_ovf[1]), 32'd1);
    read_lit(BASE + 1, 16'hFFFF, "cnt1_sat");
    write(BASE + 1, 16'h0000);
    chk("ovf1_clr", 32'(stat_ovf[1]), 32'd0);
    read_lit(BASE + 1, 16'h0000, "cnt1_clr");

    // Same-cycle read and write: read sees the old value
    write(7, 16'h00FF);
    we = 1; re = 1; addr = AW'(7); din = 16'h1234;
    tick();
    idle();
    chk("rw_old", 32'(dout), 32'h00FF);
    read_lit(7, 16'h1234, "rw_new");

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      we       = ($urandom % 4) == 0;
      re       = ($urandom % 3) == 0;
      addr     = AW'($urandom_range(0, (1 << AW) - 1));
      din      = DW'($urandom);
      stat_inc = NS'($urandom);
      tick();
    end
    idle();
    tick();

    // Reset in the middle of a pulse and a sync transfer
    write(0, 16'h5555);
    write(1, 16'hBEEF);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_dout",  32'(dout),       32'd0);
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_ctrl",  32'(ctrl_out),   32'd0);
    chk("mid_rst_pulse", 32'(cmd_pulse),  32'd0);
    chk("mid_rst_ovf",   32'(stat_ovf),   32'd0);
    repeat (2) tick();
    rst_n = 1;
    repeat (3) begin
      tick();
      chk("post_rst_pulse", 32'(cmd_pulse), 32'd0);
      chk("post_rst_ctrl",  32'(ctrl_out),  32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
